block_gather: RTL and testbench
===============================

BLOCK_GATHER -- requirements
Module: block_gather

Interface
REQ-001 SHALL have parameter BIN_I, default 16, integer bits per bin.
REQ-002 SHALL have parameter BIN_F, default 16, fractional bits per bin.
REQ-003 SHALL have parameter CELL_W, default 80, cells per row.
REQ-004 SHALL have parameter CELL_H, default 60, cell rows per frame.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset; synchronous and active-high.
REQ-007 SHALL have port cell_bin, input, 9*(BIN_I+BIN_F) bits: one cell histogram; bin j occupies bits [(j+1)*(BIN_I+BIN_F)-1 : j*(BIN_I+BIN_F)].
REQ-008 SHALL have port cell_valid, input, 1 bit: cell_bin is valid this cycle.
REQ-009 SHALL have ports bin_a, bin_b, bin_c, bin_d, output, 9*(BIN_I+BIN_F) bits each: block quadrants top-left, top-right, bottom-left, bottom-right; same bin packing as cell_bin.
REQ-010 SHALL have port o_valid, output, 1 bit: bin_a..bin_d hold one block.
REQ-011 SHALL have port clear, output, 1 bit: end-of-frame pulse to the normalizer's block counter.

Function
REQ-012 SHALL accept cells in raster order, row 0 col 0 first; column counter col runs 0..CELL_W-1 and row counter row runs 0..CELL_H-1, each advancing only on cell_valid.
REQ-013 SHALL allow arbitrary idle gaps between cell_valid pulses with no loss of state; there is no backpressure.
REQ-014 SHALL store the previous cell row in a CELL_W-entry line buffer, one cell per entry; entry col is read, then overwritten with cell_bin, on each accepted cell.
REQ-015 SHALL keep a register top_prev holding the line-buffer word read for the previous accepted cell, and a register cur_prev holding the previous accepted cell_bin.
REQ-016 SHALL, for an accepted cell at (row,col) with row>=1 and col>=1, register bin_a=top_prev, bin_b=line[col] (old value), bin_c=cur_prev, bin_d=cell_bin, and assert o_valid on the next cycle: latency exactly 1 cycle.
REQ-017 SHALL hold o_valid low for one cycle for each accepted cell with row==0 or col==0, and in every cycle without cell_valid; bin_a..bin_d keep their last value while o_valid is low.
REQ-018 SHALL emit (CELL_W-1)*(CELL_H-1) blocks per frame (4661 at default parameters), in raster order of block position.
REQ-019 SHALL wrap col to 0 after CELL_W-1 and increment row; after the cell at (CELL_H-1, CELL_W-1), row and col SHALL both return to 0 and the next cell starts a new frame.
REQ-020 SHALL treat data carried over from the previous frame as don't-care: row 0 of the new frame produces no blocks.

Reset
REQ-021 SHALL, on rst, clear row, col, o_valid, clear, bin_a..bin_d, top_prev and cur_prev to 0; line-buffer contents are not reset.
REQ-022 SHALL, when rst is asserted mid-frame, discard the partial frame, treat the first cell after deassertion as (0,0), and produce no block output in the reset cycle.

Configuration
REQ-023 SHALL, with macro BLOCK_GATHER_CLEAR_EN defined, drive clear high for exactly one cycle, coincident with o_valid for the last block of a frame at (CELL_H-1, CELL_W-1).
REQ-024 SHALL, without BLOCK_GATHER_CLEAR_EN defined, tie clear to 0; all other behaviour is identical.

Structure
REQ-025 SHALL take BIN_W = BIN_I+BIN_F, the 9-bins-per-cell constant and the default CELL_W/CELL_H from the shared hog_pkg package, and SHALL size the counters from that package using $clog2.
REQ-026 SHALL implement the line buffer as sub-module cell_line_buf: single port, read-before-write, CELL_W x 9*BIN_W bits, suitable for block-RAM inference.

Verification
REQ-027 SHALL pass this check: full frame with cell_bin bin0 = row*256+col and other bins 0 -> exactly 4661 o_valid pulses; the block for cell (1,1) gives bin_a..bin_d bin0 = 0x000, 0x001, 0x100, 0x101.
REQ-028 SHALL pass this check: cell_valid on every 3rd cycle across a full frame -> same 4661 blocks with identical data as back-to-back input; each o_valid occurs 1 cycle after its cell.
REQ-029 SHALL pass this check: row wrap, cell (2,0) followed by cell (2,1) -> no output for (2,0); block for (2,1) has bin_a=(1,0), bin_b=(1,1), bin_c=(2,0), bin_d=(2,1).
REQ-030 SHALL pass this check: two frames back-to-back -> 9322 blocks total; with BLOCK_GATHER_CLEAR_EN defined, clear pulses exactly twice, each with the (59,79) block; without it, clear stays 0.
REQ-031 SHALL pass this check: rst for 1 cycle after 500 cells, then a full frame -> o_valid low in the cycle after rst; 4661 blocks; first block is position (1,1) of the new frame.
REQ-032 SHALL pass this check: all bins 0xFFFFFFFF -> outputs carry full-width values with no truncation.

Source files
------------

// File: rtl/hog_pkg.sv
// Shared HOG pipeline constants: bin widths, bins per cell, default cell grid
// and helpers for sizing counters and cell-wide buses.
package hog_pkg;
  localparam int HOG_BIN_I  = 16;
  localparam int HOG_BIN_F  = 16;
  localparam int BIN_W      = HOG_BIN_I + HOG_BIN_F;
  localparam int NBINS      = 9;
  localparam int CELL_W_DEF = 80;
  localparam int CELL_H_DEF = 60;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of one packed cell histogram for a given bin format.
  function automatic int cell_bits(input int bin_i, input int bin_f);
    return NBINS * (bin_i + bin_f);
  endfunction
endpackage

// File: rtl/cell_line_buf.sv
// Single-port, read-before-write line buffer holding one cell row.
// Only the read register is reset; the storage array is left as-is.
module cell_line_buf #(
  parameter int DEPTH = 80,
  parameter int WIDTH = 288,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= wdata;
  end

  // Old contents appear on rdata the cycle after the access.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (en) rdata <= mem[addr];
  end
endmodule

// File: rtl/block_gather.sv
// Gathers 2x2 cell neighbourhoods into blocks from a raster cell stream.
// Optional macro BLOCK_GATHER_CLEAR_EN enables the end-of-frame clear pulse.
module block_gather
  import hog_pkg::*;
#(
  parameter int BIN_I  = HOG_BIN_I,
  parameter int BIN_F  = HOG_BIN_F,
  parameter int CELL_W = CELL_W_DEF,
  parameter int CELL_H = CELL_H_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [cell_bits(BIN_I,BIN_F)-1:0] cell_bin,
  input  logic                             cell_valid,
  output logic [cell_bits(BIN_I,BIN_F)-1:0] bin_a,
  output logic [cell_bits(BIN_I,BIN_F)-1:0] bin_b,
  output logic [cell_bits(BIN_I,BIN_F)-1:0] bin_c,
  output logic [cell_bits(BIN_I,BIN_F)-1:0] bin_d,
  output logic                             o_valid,
  output logic                             clear
);
  localparam int CW    = cell_bits(BIN_I, BIN_F);
  localparam int COL_W = cnt_w(CELL_W);
  localparam int ROW_W = cnt_w(CELL_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(CELL_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CELL_H - 1);

  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [CW-1:0]    top_prev;
  logic [CW-1:0]    cur_prev_reg;
  logic [CW-1:0]    bin_a_reg, bin_c_reg, bin_d_reg, bin_b_hold_reg;
  logic             b_live_reg;
  logic             o_valid_reg;
  logic             accept, is_block, col_end, row_end;

  assign accept   = cell_valid && !rst;
  assign is_block = (row_reg != '0) && (col_reg != '0);
  assign col_end  = (col_reg == COL_LAST);
  assign row_end  = (row_reg == ROW_LAST);

  // The read register of the buffer is top_prev: it changes only on accepted
  // cells, so between accepts it holds the word read for the previous cell,
  // and in the cycle after an accept it holds line[col] old, i.e. bin_b.
  cell_line_buf #(
    .DEPTH (CELL_W),
    .WIDTH (CW),
    .AW    (COL_W)
  ) u_line (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .addr  (col_reg),
    .wdata (cell_bin),
    .rdata (top_prev)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (accept) begin
      col_reg <= col_end ? '0 : col_reg + 1'b1;
      if (col_end) row_reg <= row_end ? '0 : row_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_prev_reg   <= '0;
      bin_a_reg      <= '0;
      bin_c_reg      <= '0;
      bin_d_reg      <= '0;
      bin_b_hold_reg <= '0;
      b_live_reg     <= 1'b0;
      o_valid_reg    <= 1'b0;
    end else begin
      o_valid_reg <= accept && is_block;
      if (accept) begin
        cur_prev_reg   <= cell_bin;
        bin_b_hold_reg <= bin_b;
        b_live_reg     <= is_block;
        if (is_block) begin
          bin_a_reg <= top_prev;
          bin_c_reg <= cur_prev_reg;
          bin_d_reg <= cell_bin;
        end
      end
    end
  end

  // bin_b follows the buffer read register while it holds the current block,
  // and a frozen copy once a non-block cell moves the read register on.
  assign bin_b   = b_live_reg ? top_prev : bin_b_hold_reg;
  assign bin_a   = bin_a_reg;
  assign bin_c   = bin_c_reg;
  assign bin_d   = bin_d_reg;
  assign o_valid = o_valid_reg;

`ifdef BLOCK_GATHER_CLEAR_EN
  logic clear_reg;
  always_ff @(posedge clk) begin
    if (rst) clear_reg <= 1'b0;
    else     clear_reg <= accept && row_end && col_end;
  end
  assign clear = clear_reg;
`else
  assign clear = 1'b0;
`endif
endmodule

// File: tb/tb_block_gather.sv
// Scoreboard bench for block_gather at default parameters; clear expectations
// follow BLOCK_GATHER_CLEAR_EN.
module tb_block_gather;
  localparam int W  = 80;
  localparam int H  = 60;
  localparam int CW = 9 * 32;
  localparam int BLOCKS = (W - 1) * (H - 1);

  typedef struct packed {
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    logic [CW-1:0] c;
    logic [CW-1:0] d;
    logic          clr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] cell_bin;
  logic          cell_valid;
  logic [CW-1:0] bin_a, bin_b, bin_c, bin_d;
  logic          o_valid, clear;

  exp_t          sb[$];
  int            tests_run = 0;
  int            tests_failed = 0;
  int            blocks = 0;
  int            clears = 0;
  int            pat_mode = 0;
  logic [31:0]   salt = 32'h0;
  logic [CW-1:0] held_a = '0, held_b = '0, held_c = '0, held_d = '0;

  always #5 clk = ~clk;

  block_gather dut (
    .clk        (clk),
    .rst        (rst),
    .cell_bin   (cell_bin),
    .cell_valid (cell_valid),
    .bin_a      (bin_a),
    .bin_b      (bin_b),
    .bin_c      (bin_c),
    .bin_d      (bin_d),
    .o_valid    (o_valid),
    .clear      (clear)
  );

  // Cell content as a pure function of its coordinates.
  function automatic logic [CW-1:0] gen(input int r, input int c);
    logic [CW-1:0] v;
    v = '0;
    for (int j = 0; j < 9; j++) begin
      if (pat_mode == 2)
        v[j*32 +: 32] = 32'hFFFF_FFFF;
      else if (j == 0)
        v[j*32 +: 32] = 32'(r * 256 + c);
      else if (pat_mode == 1)
        v[j*32 +: 32] = salt ^ (32'(j) * 32'h0123_4567) ^ 32'(r << 20) ^ 32'(c << 8);
    end
    return v;
  endfunction

  task automatic check_fail(input string name, input logic [CW-1:0] got, input logic [CW-1:0] want);
    tests_failed++;
    $display("[TB] FAIL %s got=%h want=%h", name, got, want);
  endtask

  task automatic step(input logic v, input int r, input int c);
    exp_t e;
    logic exp_clr;
    @(negedge clk);
    rst        = 1'b0;
    cell_valid = v;
    cell_bin   = v ? gen(r, c) : {9{$urandom}};
    if (v && r >= 1 && c >= 1)
      sb.push_back('{gen(r-1, c-1), gen(r-1, c), gen(r, c-1), gen(r, c), (r == H-1 && c == W-1)});
    @(posedge clk);
    #1;
    exp_clr = 1'b0;
    tests_run++;
    if (o_valid === 1'b1) begin
      blocks++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_o_valid got=1 want=0 (cell %0d,%0d)", r, c);
      end else begin
        e = sb.pop_front();
`ifdef BLOCK_GATHER_CLEAR_EN
        exp_clr = e.clr;
`endif
        if (bin_a !== e.a) check_fail($sformatf("bin_a(%0d,%0d)", r, c), bin_a, e.a);
        if (bin_b !== e.b) check_fail($sformatf("bin_b(%0d,%0d)", r, c), bin_b, e.b);
        if (bin_c !== e.c) check_fail($sformatf("bin_c(%0d,%0d)", r, c), bin_c, e.c);
        if (bin_d !== e.d) check_fail($sformatf("bin_d(%0d,%0d)", r, c), bin_d, e.d);
      end
      held_a = e.a; held_b = e.b; held_c = e.c; held_d = e.d;
    end else begin
      if (o_valid !== 1'b0 || sb.size() != 0) begin
        tests_failed++;
        $display("[TB] FAIL o_valid(%0d,%0d) got=%b want=%0d", r, c, o_valid, sb.size());
        sb.delete();
      end
      if ({bin_a, bin_b, bin_c, bin_d} !== {held_a, held_b, held_c, held_d}) begin
        tests_failed++;
        $display("[TB] FAIL hold(%0d,%0d) got_a=%h got_b=%h want_a=%h want_b=%h",
                 r, c, bin_a[31:0], bin_b[31:0], held_a[31:0], held_b[31:0]);
      end
    end
    if (clear === 1'b1) clears++;
    if (clear !== exp_clr) begin
      tests_failed++;
      $display("[TB] FAIL clear(%0d,%0d) got=%b want=%b", r, c, clear, exp_clr);
    end
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    rst        = 1'b1;
    cell_valid = v;
    cell_bin   = {9{$urandom}};
    @(posedge clk);
    #1;
    sb.delete();
    tests_run++;
    if (o_valid !== 1'b0 || clear !== 1'b0 || {bin_a, bin_b, bin_c, bin_d} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got_ov=%b got_clr=%b got_a=%h want=0",
               o_valid, clear, bin_a[31:0]);
    end
    held_a = '0; held_b = '0; held_c = '0; held_d = '0;
  endtask

  task automatic run_frame(input int gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, r, c);
        repeat (gap) step(1'b0, 0, 0);
      end
  endtask

  task automatic check_count(input string name, input int got, input int want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cell_valid = 1'b0; cell_bin = '0;
    do_reset(1'b0);
    do_reset(1'b1);
    step(1'b0, 0, 0);
  endtask

  task automatic test_full_frame();
    do_reset(1'b0);
    pat_mode = 0; blocks = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, r, c);
        if (r == 1 && c == 1) begin
          tests_run++;
          if ({bin_a[31:0], bin_b[31:0], bin_c[31:0], bin_d[31:0]} !==
              {32'h000, 32'h001, 32'h100, 32'h101}) begin
            tests_failed++;
            $display("[TB] FAIL block_1_1 got=%h %h %h %h want=0 1 100 101",
                     bin_a[31:0], bin_b[31:0], bin_c[31:0], bin_d[31:0]);
          end
        end
      end
    check_count("full_frame_blocks", blocks, BLOCKS);
  endtask

  task automatic test_gapped();
    do_reset(1'b0);
    pat_mode = 1; salt = 32'h5A5A_0001; blocks = 0;
    run_frame(2);
    check_count("gapped_blocks", blocks, BLOCKS);
  endtask

  task automatic test_row_wrap();
    do_reset(1'b0);
    pat_mode = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) step(1'b1, r, c);
    step(1'b1, 2, 0);
    tests_run++;
    if (o_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_2_0 got=%b want=0", o_valid);
    end
    step(1'b1, 2, 1);
    tests_run++;
    if (o_valid !== 1'b1 ||
        {bin_a[31:0], bin_b[31:0], bin_c[31:0], bin_d[31:0]} !==
        {32'h100, 32'h101, 32'h200, 32'h201}) begin
      tests_failed++;
      $display("[TB] FAIL wrap_2_1 got=%b %h %h %h %h want=1 100 101 200 201",
               o_valid, bin_a[31:0], bin_b[31:0], bin_c[31:0], bin_d[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    pat_mode = 1; salt = 32'hC0DE_0002; blocks = 0; clears = 0;
    run_frame(0);
    salt = 32'h1234_0003;
    run_frame(0);
    check_count("two_frame_blocks", blocks, 2 * BLOCKS);
`ifdef BLOCK_GATHER_CLEAR_EN
    check_count("two_frame_clears", clears, 2);
`else
    check_count("two_frame_clears", clears, 0);
`endif
  endtask

  task automatic test_mid_reset();
    do_reset(1'b0);
    pat_mode = 1; salt = 32'hBEEF_0004;
    for (int i = 0; i < 500; i++) step(1'b1, i / W, i % W);
    do_reset(1'b1);
    blocks = 0;
    run_frame(0);
    check_count("post_reset_blocks", blocks, BLOCKS);
  endtask

  task automatic test_all_ones();
    do_reset(1'b0);
    pat_mode = 2; blocks = 0;
    run_frame(0);
    check_count("all_ones_blocks", blocks, BLOCKS);
    tests_run++;
    if ({bin_a, bin_b, bin_c, bin_d} !== {4 * CW{1'b1}}) begin
      tests_failed++;
      $display("[TB] FAIL all_ones got_a=%h got_d=%h want=all ones", bin_a, bin_d);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gapped();
    test_row_wrap();
    test_back_to_back();
    test_mid_reset();
    test_all_ones();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
